frame_shadow_regs: RTL and testbench
====================================

# frame_shadow_regs

Double-buffered parameter store sitting directly upstream of the VGA controller. It drives the controller's sprite positions, platform colours, squid colour and `char_sel` from an active register bank that changes only at the start of vertical blanking, so the picture never tears mid-frame. Software writes a shadow bank through a simple write port, then requests a commit. The block copies shadow to active on the next frame boundary, detected from the controller's own horizontal and vertical counts.

## Interface
Parameters:
- `H_BOUNDARY`, default 0: horizontal count at which the boundary is taken.
- `V_ACTIVE`, default 480: first vertical count of blanking. The boundary is `v_count == V_ACTIVE && h_count == H_BOUNDARY`.
- `NUM_SPRITES`, default 11: number of sprite xy / platform colour pairs.

Ports:
- `clk` in 1: pixel clock, the same clock that drives the controller's counters.
- `rst` in 1: asynchronous, active-low reset.
- `h_count` in 32: horizontal counter value from the controller.
- `v_count` in 32: vertical counter value from the controller.
- `wr_en` in 1: shadow write strobe; one write per cycle.
- `wr_addr` in 5: shadow register address.
- `wr_data` in 32: write data.
- `commit_req` in 1: request a shadow-to-active copy at the next boundary.
- `commit_pending` out 1: high while a commit is waiting for the boundary.
- `commit_ack` out 1: one-cycle pulse, the cycle after the active bank updates.
- `frame_start` out 1: one-cycle pulse, registered, one cycle after each boundary.
- `frame_count` out 16: count of boundaries seen.
- `sprite_xy_flat` out 32*NUM_SPRITES: active sprite xy; sprite k occupies bits [32k+31:32k].
- `platform_color_flat` out 24*NUM_SPRITES: active platform colours, packed the same way.
- `color_squid` out 24: active squid colour.
- `char_sel` out 32: active character select.

## Operation
- Address map (k = 0..NUM_SPRITES-1):
  - k: sprite k xy, 32 bits stored verbatim.
  - 11+k: platform k colour, `wr_data[23:0]` stored.
  - 22: squid colour, `wr_data[23:0]`.
  - 23: `char_sel`, 32 bits.
  - Addresses 24–31: writes ignored, no side effects.
- Writes always go to the shadow bank, in every state. The active bank changes only in the COMMIT state.
- FSM:
  - IDLE: `commit_req` goes to PENDING.
  - PENDING: `commit_pending`=1. Further `commit_req` is ignored (requests merge into a single commit). On a boundary cycle, go to COMMIT.
  - COMMIT: all active registers load the shadow bank in one cycle. `commit_ack` pulses the next cycle. Return to IDLE.
- `commit_req` in IDLE on a boundary cycle enters PENDING. The commit waits for the next frame's boundary; a request never commits in the cycle it is made.
- Write in the COMMIT cycle: the active bank takes the pre-write shadow value; the shadow takes the new value. That write lands in active only on a later commit.
- Write in the boundary cycle while PENDING: the write is included in the copy, because the copy happens in COMMIT, one cycle later.
- `frame_count` increments on every boundary in any state and wraps from 16'hFFFF to 0.
- Reset mid-PENDING or mid-COMMIT: return to IDLE; shadow and active banks are cleared; no `commit_ack`.

## Timing
- Reset values: every shadow and active register 0, `commit_pending`=0, `commit_ack`=0, `frame_start`=0, `frame_count`=0. All flops use the asynchronous clear.
- Boundary is detected combinationally at cycle B.
- Cycle B+1: `frame_start`=1, `frame_count` updated, FSM in COMMIT.
- Rising edge ending B+1: active bank updated.
- Cycle B+2: `commit_ack`=1, `commit_pending`=0.
- The active bank is stable from B+2 until the next boundary. Latency from `commit_req` to a visible update is at most one frame plus 2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SHADOW_READBACK_EN` defined:
  - Adds ports `rd_addr` in 5 and `rd_data` out 32.
  - `rd_data` is registered, 1-cycle latency, and returns the shadow contents at `rd_addr`, zero-extended for colours.
  - Unmapped addresses read 0. `rd_data` resets to 0.
- `SHADOW_READBACK_EN` undefined: the ports are absent and no read mux is built.

## Test plan
- Reset, then release: all active outputs 0, `frame_count`=0. After the counters pass (v=480, h=0) once, `frame_count`=1 and `frame_start` pulses exactly once.
- Write addr 0 = 32'h0064_00C8, then `commit_req` at v=100. `sprite_xy_flat[31:0]` stays 0 until B+1. At B+2 it reads 32'h0064_00C8 and `commit_ack` is a single-cycle pulse.
- Write addr 12 = 32'hAB12_34FF, commit: `platform_color_flat[47:24]`=24'h1234FF. Write addr 27 = 32'hFFFF_FFFF, commit: no active output changes.
- Assert `commit_req` on the boundary cycle itself: no update that frame; update and `commit_ack` one frame later. Three `commit_req` pulses while PENDING give exactly one `commit_ack`.
- Write addr 23 = 5 in the COMMIT cycle after shadow holds 3: `char_sel`=3. After the next commit, `char_sel`=5.
- Assert `rst` low while PENDING: the FSM returns to IDLE, and no `commit_ack` occurs at the following boundary.

Source files
------------

// File: rtl/frame_shadow_regs.sv
// frame_shadow_regs
// Double-buffered parameter store for the VGA controller. Software writes a
// shadow bank; a commit request copies shadow to active at the next frame
// boundary (v_count == V_ACTIVE && h_count == H_BOUNDARY), so the picture
// never changes mid-frame.
// Optional build macro: SHADOW_READBACK_EN adds a registered shadow read port
// (rd_addr / rd_data).
module frame_shadow_regs #(
  parameter int H_BOUNDARY  = 0,
  parameter int V_ACTIVE    = 480,
  parameter int NUM_SPRITES = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 h_count,
  input  logic [31:0]                 v_count,
  input  logic                        wr_en,
  input  logic [4:0]                  wr_addr,
  input  logic [31:0]                 wr_data,
  input  logic                        commit_req,
`ifdef SHADOW_READBACK_EN
  input  logic [4:0]                  rd_addr,
  output logic [31:0]                 rd_data,
`endif
  output logic                        commit_pending,
  output logic                        commit_ack,
  output logic                        frame_start,
  output logic [15:0]                 frame_count,
  output logic [32*NUM_SPRITES-1:0]   sprite_xy_flat,
  output logic [24*NUM_SPRITES-1:0]   platform_color_flat,
  output logic [23:0]                 color_squid,
  output logic [31:0]                 char_sel
);

  // Register map bases. Platform colours start right after the 11 sprite slots.
  localparam logic [4:0] ADDR_PLAT_BASE = 5'd11;
  localparam logic [4:0] ADDR_SQUID     = 5'd22;
  localparam logic [4:0] ADDR_CHAR      = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] sprite_sh_q  [NUM_SPRITES];
  logic [31:0] sprite_sh_d  [NUM_SPRITES];
  logic [23:0] plat_sh_q    [NUM_SPRITES];
  logic [23:0] plat_sh_d    [NUM_SPRITES];
  logic [23:0] squid_sh_q;
  logic [23:0] squid_sh_d;
  logic [31:0] char_sh_q;
  logic [31:0] char_sh_d;

  logic [31:0] sprite_act_q [NUM_SPRITES];
  logic [31:0] sprite_act_d [NUM_SPRITES];
  logic [23:0] plat_act_q   [NUM_SPRITES];
  logic [23:0] plat_act_d   [NUM_SPRITES];
  logic [23:0] squid_act_q;
  logic [23:0] squid_act_d;
  logic [31:0] char_act_q;
  logic [31:0] char_act_d;

  state_t      state_q;
  state_t      state_d;
  logic        commit_pending_q;
  logic        commit_pending_d;
  logic        commit_ack_q;
  logic        commit_ack_d;
  logic        frame_start_q;
  logic        frame_start_d;
  logic [15:0] frame_count_q;
  logic [15:0] frame_count_d;

  logic        boundary;
  logic        load_active;

  // Frame boundary: first blanking line at the chosen horizontal position.
  assign boundary = (v_count == 32'(V_ACTIVE)) && (h_count == 32'(H_BOUNDARY));

  // The active bank copies the shadow during the single COMMIT cycle. Because
  // the copy uses the registered shadow, a write in that same cycle is not
  // included, while a write on the boundary cycle (one cycle earlier) is.
  assign load_active = (state_q == ST_COMMIT);

  // ---------------------------------------------------------------------------
  // Shadow bank write decode: writes land in the shadow in every FSM state.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUM_SPRITES; k++) begin
      sprite_sh_d[k] = sprite_sh_q[k];
      plat_sh_d[k]   = plat_sh_q[k];
      if (wr_en && (wr_addr == 5'(k))) begin
        sprite_sh_d[k] = wr_data;
      end
      if (wr_en && (wr_addr == (ADDR_PLAT_BASE + 5'(k)))) begin
        plat_sh_d[k] = wr_data[23:0];
      end
    end
    squid_sh_d = squid_sh_q;
    char_sh_d  = char_sh_q;
    if (wr_en && (wr_addr == ADDR_SQUID)) begin
      squid_sh_d = wr_data[23:0];
    end
    if (wr_en && (wr_addr == ADDR_CHAR)) begin
      char_sh_d = wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Active bank next-state: hold, or take the whole shadow bank at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUM_SPRITES; k++) begin
      sprite_act_d[k] = load_active ? sprite_sh_q[k] : sprite_act_q[k];
      plat_act_d[k]   = load_active ? plat_sh_q[k]   : plat_act_q[k];
    end
    squid_act_d = load_active ? squid_sh_q : squid_act_q;
    char_act_d  = load_active ? char_sh_q  : char_act_q;
  end

  // Shadow and active bank registers, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        sprite_sh_q[k]  <= '0;
        plat_sh_q[k]    <= '0;
        sprite_act_q[k] <= '0;
        plat_act_q[k]   <= '0;
      end
      squid_sh_q  <= '0;
      char_sh_q   <= '0;
      squid_act_q <= '0;
      char_act_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        sprite_sh_q[k]  <= sprite_sh_d[k];
        plat_sh_q[k]    <= plat_sh_d[k];
        sprite_act_q[k] <= sprite_act_d[k];
        plat_act_q[k]   <= plat_act_d[k];
      end
      squid_sh_q  <= squid_sh_d;
      char_sh_q   <= char_sh_d;
      squid_act_q <= squid_act_d;
      char_act_q  <= char_act_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Commit FSM and frame bookkeeping. Requests made while PENDING or COMMIT
  // are absorbed; a request in IDLE always waits for a later boundary.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (commit_req) state_d = ST_PENDING;
      ST_PENDING: if (boundary)   state_d = ST_COMMIT;
      ST_COMMIT:                  state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
    // Pending stays high through the COMMIT cycle and drops with the ack.
    commit_pending_d = (state_d != ST_IDLE);
    commit_ack_d     = (state_q == ST_COMMIT);
    frame_start_d    = boundary;
    frame_count_d    = frame_count_q + 16'(boundary);
  end

  // FSM state and its registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      commit_pending_q <= 1'b0;
      commit_ack_q     <= 1'b0;
      frame_start_q    <= 1'b0;
      frame_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      commit_pending_q <= commit_pending_d;
      commit_ack_q     <= commit_ack_d;
      frame_start_q    <= frame_start_d;
      frame_count_q    <= frame_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional shadow readback, one cycle of latency.
  // ---------------------------------------------------------------------------
`ifdef SHADOW_READBACK_EN
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  // Select the addressed shadow register; colours are zero-extended and
  // unmapped addresses return zero.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      if (rd_addr == 5'(k)) begin
        rd_data_d = sprite_sh_q[k];
      end
      if (rd_addr == (ADDR_PLAT_BASE + 5'(k))) begin
        rd_data_d = {8'h00, plat_sh_q[k]};
      end
    end
    if (rd_addr == ADDR_SQUID) begin
      rd_data_d = {8'h00, squid_sh_q};
    end
    if (rd_addr == ADDR_CHAR) begin
      rd_data_d = char_sh_q;
    end
  end

  // Readback output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
`endif

  // ---------------------------------------------------------------------------
  // Output packing: every output comes straight from a flop.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_pack
      assign sprite_xy_flat[32*gi +: 32]      = sprite_act_q[gi];
      assign platform_color_flat[24*gi +: 24] = plat_act_q[gi];
    end
  endgenerate

  assign color_squid    = squid_act_q;
  assign char_sel       = char_act_q;
  assign commit_pending = commit_pending_q;
  assign commit_ack     = commit_ack_q;
  assign frame_start    = frame_start_q;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_frame_shadow_regs.sv
// Testbench for frame_shadow_regs: directed scenarios plus a random phase,
// every cycle compared against a register-map level reference model.
module tb_frame_shadow_regs;

  localparam int NS    = 11;
  localparam int H_TOT = 4;
  localparam int V_TOT = 484;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] h_count;
  logic [31:0] v_count;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        commit_req;
  logic        commit_pending;
  logic        commit_ack;
  logic        frame_start;
  logic [15:0] frame_count;
  logic [32*NS-1:0] sprite_xy_flat;
  logic [24*NS-1:0] platform_color_flat;
  logic [23:0] color_squid;
  logic [31:0] char_sel;
`ifdef SHADOW_READBACK_EN
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] m_rd;
`endif

  frame_shadow_regs dut (
    .clk                 (clk),
    .rst                 (rst),
    .h_count             (h_count),
    .v_count             (v_count),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .commit_req          (commit_req),
`ifdef SHADOW_READBACK_EN
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
`endif
    .commit_pending      (commit_pending),
    .commit_ack          (commit_ack),
    .frame_start         (frame_start),
    .frame_count         (frame_count),
    .sprite_xy_flat      (sprite_xy_flat),
    .platform_color_flat (platform_color_flat),
    .color_squid         (color_squid),
    .char_sel            (char_sel)
  );

  int total = 0;
  int bad   = 0;
  int ack_seen = 0;

  // Reference model, indexed by register address (colours kept masked).
  logic [31:0] m_sh  [32];
  logic [31:0] m_act [32];
  bit          m_wait;   // request accepted, waiting for a boundary
  bit          m_copy;   // copy scheduled for the coming edge
  bit          m_fs;
  bit          m_ack;
  logic [15:0] m_fc;

  task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 32; a++) begin
      m_sh[a]  = '0;
      m_act[a] = '0;
    end
    m_wait = 0; m_copy = 0; m_fs = 0; m_ack = 0; m_fc = '0;
`ifdef SHADOW_READBACK_EN
    m_rd = '0;
`endif
  endtask

  // Advance the model by one clock edge using the inputs of the cycle that ended.
  task automatic model_edge();
    bit bnd;
    bit nxt;
    if (!rst) begin
      model_reset();
      return;
    end
    bnd = (v_count == 32'd480) && (h_count == 32'd0);
    nxt = 0;
    m_ack = m_copy;
    m_fs  = bnd;
    if (bnd) m_fc++;
`ifdef SHADOW_READBACK_EN
    m_rd = (rd_addr < 5'd24) ? m_sh[rd_addr] : 32'd0;
`endif
    if (m_copy) for (int a = 0; a < 32; a++) m_act[a] = m_sh[a];
    if (wr_en && wr_addr < 5'd24)
      m_sh[wr_addr] = (wr_addr >= 5'd11 && wr_addr <= 5'd22) ? {8'h00, wr_data[23:0]} : wr_data;
    if (m_wait && bnd) begin
      m_wait = 0;
      nxt = 1;
    end else if (!m_wait && !m_copy && commit_req) begin
      m_wait = 1;
    end
    m_copy = nxt;
  endtask

  task automatic check_all();
    logic [351:0] es;
    logic [263:0] ep;
    for (int k = 0; k < NS; k++) begin
      es[32*k +: 32] = m_act[k];
      ep[24*k +: 24] = m_act[11+k][23:0];
    end
    chk("frame_start",    352'(frame_start),    352'(m_fs));
    chk("frame_count",    352'(frame_count),    352'(m_fc));
    chk("commit_pending", 352'(commit_pending), 352'(m_wait || m_copy));
    chk("commit_ack",     352'(commit_ack),     352'(m_ack));
    chk("sprite_xy_flat", sprite_xy_flat,       es);
    chk("platform_color", 352'(platform_color_flat), 352'(ep));
    chk("color_squid",    352'(color_squid),    352'(m_act[22][23:0]));
    chk("char_sel",       352'(char_sel),       352'(m_act[23]));
`ifdef SHADOW_READBACK_EN
    chk("rd_data",        352'(rd_data),        352'(m_rd));
`endif
  endtask

  // One clock: update model at the edge, compare 1 ns later, then set up the
  // default inputs and counter values for the next cycle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (commit_ack === 1'b1) ack_seen++;
    wr_en = 1'b0;
    commit_req = 1'b0;
`ifdef SHADOW_READBACK_EN
    rd_addr = 5'($urandom_range(0, 31));
`endif
    if (h_count == 32'(H_TOT - 1)) begin
      h_count = '0;
      v_count = (v_count == 32'(V_TOT - 1)) ? '0 : v_count + 32'd1;
    end else begin
      h_count = h_count + 32'd1;
    end
  endtask

  task automatic run_to(input int vt, input int ht);
    int n;
    n = 0;
    while (!(v_count == 32'(vt) && h_count == 32'(ht))) begin
      tick();
      n++;
      if (n > 3 * V_TOT * H_TOT) begin
        total++;
        bad++;
        $display("FAIL run_to timeout observed=v%0d/h%0d required=v%0d/h%0d", v_count, h_count, vt, ht);
        return;
      end
    end
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    $display("write addr=%0d data=%08h", a, d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
  endtask

  // Request a commit and stop at cycle B+2 of the boundary that serves it.
  task automatic do_commit();
    $display("commit request at v=%0d h=%0d", v_count, h_count);
    commit_req = 1'b1;
    tick();
    run_to(480, 0);
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst = 1'b0;
    h_count = '0;
    v_count = 32'd478;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit_req = 1'b0;
`ifdef SHADOW_READBACK_EN
    rd_addr = '0;
`endif
    model_reset();

    // Reset state and first boundary
    repeat (3) tick();
    chk("rst_frame_count", 352'(frame_count), 352'(0));
    chk("rst_sprite", sprite_xy_flat, 352'(0));
    chk("rst_pending", 352'(commit_pending), 352'(0));
    rst = 1'b1;
    run_to(480, 0);
    chk("pre_boundary_count", 352'(frame_count), 352'(0));
    tick();
    chk("first_frame_start", 352'(frame_start), 352'(1));
    chk("first_frame_count", 352'(frame_count), 352'(1));
    tick();
    chk("frame_start_single", 352'(frame_start), 352'(0));

    // Sprite 0 commit, latency through B, B+1, B+2
    write(5'd0, 32'h0064_00C8);
    run_to(100, 0);
    commit_req = 1'b1;
    $display("commit request at v=100");
    tick();
    run_to(480, 0);
    chk("B_sprite0", 352'(sprite_xy_flat[31:0]), 352'(0));
    chk("B_pending", 352'(commit_pending), 352'(1));
    tick();
    chk("B1_sprite0", 352'(sprite_xy_flat[31:0]), 352'(0));
    chk("B1_ack", 352'(commit_ack), 352'(0));
    tick();
    chk("B2_sprite0", 352'(sprite_xy_flat[31:0]), 352'(32'h0064_00C8));
    chk("B2_ack", 352'(commit_ack), 352'(1));
    chk("B2_pending", 352'(commit_pending), 352'(0));
    tick();
    chk("B3_ack", 352'(commit_ack), 352'(0));

    // Platform colour masking and an unmapped write
    write(5'd12, 32'hAB12_34FF);
    do_commit();
    chk("plat1", 352'(platform_color_flat[47:24]), 352'(24'h1234FF));
    write(5'd27, 32'hFFFF_FFFF);
    do_commit();
    chk("unmapped_sprite", sprite_xy_flat, 352'h0064_00C8);
    chk("unmapped_plat", 352'(platform_color_flat), 352'h1234FF_000000);
    chk("unmapped_squid", 352'(color_squid), 352'(0));
    chk("unmapped_char", 352'(char_sel), 352'(0));

    // Request on the boundary cycle waits a whole frame
    write(5'd22, 32'h77AA_5500);
    run_to(480, 0);
    $display("commit request on boundary cycle");
    commit_req = 1'b1;
    tick();
    tick();
    chk("bnd_req_squid_early", 352'(color_squid), 352'(0));
    chk("bnd_req_no_ack", 352'(commit_ack), 352'(0));
    chk("bnd_req_pending", 352'(commit_pending), 352'(1));
    run_to(480, 0);
    tick();
    tick();
    chk("bnd_req_squid", 352'(color_squid), 352'(24'hAA5500));
    chk("bnd_req_ack", 352'(commit_ack), 352'(1));

    // Three requests merge into one commit
    write(5'd1, 32'h1111_2222);
    a0 = ack_seen;
    commit_req = 1'b1;
    tick();
    tick();
    commit_req = 1'b1;
    tick();
    run_to(300, 0);
    commit_req = 1'b1;
    tick();
    run_to(480, 0);
    repeat (6) tick();
    chk("merged_acks", 352'(ack_seen - a0), 352'(1));
    chk("merged_sprite1", 352'(sprite_xy_flat[63:32]), 352'(32'h1111_2222));

    // Write during the COMMIT cycle lands only on the following commit
    write(5'd23, 32'd3);
    do_commit();
    chk("char_first", 352'(char_sel), 352'(3));
    commit_req = 1'b1;
    tick();
    run_to(480, 0);
    tick();
    wr_en = 1'b1;
    wr_addr = 5'd23;
    wr_data = 32'd5;
    $display("write addr=23 data=00000005 in commit cycle");
    tick();
    chk("char_commit_cycle", 352'(char_sel), 352'(3));
    chk("char_commit_ack", 352'(commit_ack), 352'(1));
    do_commit();
    chk("char_later", 352'(char_sel), 352'(5));

    // Reset while PENDING
    write(5'd2, 32'hDEAD_BEEF);
    commit_req = 1'b1;
    tick();
    run_to(200, 0);
    chk("pre_rst_pending", 352'(commit_pending), 352'(1));
    rst = 1'b0;
    $display("reset asserted while pending");
    tick();
    tick();
    chk("rst_pending_clr", 352'(commit_pending), 352'(0));
    chk("rst_char_clr", 352'(char_sel), 352'(0));
    rst = 1'b1;
    a0 = ack_seen;
    run_to(480, 0);
    repeat (4) tick();
    chk("rst_no_ack", 352'(ack_seen - a0), 352'(0));
    chk("rst_count", 352'(frame_count), 352'(1));
    chk("rst_sprite2", 352'(sprite_xy_flat[95:64]), 352'(0));

    // Random traffic against the model
    commit_req = 1'b1;
    tick();
    for (int i = 0; i < 3 * V_TOT * H_TOT; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_en = 1'b1;
        wr_addr = 5'($urandom_range(0, 31));
        wr_data = $urandom;
      end
      if ($urandom_range(0, 299) == 0) commit_req = 1'b1;
      if (v_count == 32'd480 && h_count == 32'd0 && $urandom_range(0, 1) == 1) commit_req = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
